// File: rtl/bus_arbiter_6502_if.sv
// Signal bundle between bus_arbiter_6502 and its neighbours (core, DMA engine, RAM).
// slave is the arbiter's view; master is the view of the blocks around it.
interface bus_arbiter_6502_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_we;
  logic        cpu_rd;
  logic        cpu_sync;
  logic        cpu_rdy;
  logic [7:0]  cpu_din;

  logic        dma_req;
  logic        dma_we;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_gnt;
  logic [7:0]  dma_rdata;
  logic        dma_rvalid;

  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_rd;
  logic [7:0]  mem_rdata;

  modport slave (
    input  cpu_addr, cpu_dout, cpu_we, cpu_rd, cpu_sync,
    output cpu_rdy, cpu_din,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output mem_addr, mem_wdata, mem_we, mem_rd,
    input  mem_rdata
  );

  modport master (
    output cpu_addr, cpu_dout, cpu_we, cpu_rd, cpu_sync,
    input  cpu_rdy, cpu_din,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  mem_addr, mem_wdata, mem_we, mem_rd,
    output mem_rdata
  );
endinterface

// File: rtl/bus_arbiter_6502.sv
// Shares the RAM port between the 6502 core and one DMA requester; DMA is granted at opcode fetches.
// Optional starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module bus_arbiter_6502 #(
  parameter int MAX_BURST    = 8,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  bus_arbiter_6502_if.slave    io_bus
);

  localparam logic [1:0] ST_CPU     = 2'd0;
  localparam logic [1:0] ST_HANDOFF = 2'd1;
  localparam logic [1:0] ST_DMA     = 2'd2;
  localparam logic [1:0] ST_RETURN  = 2'd3;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_DMA  = 2'd2;

  if (MAX_BURST < 1 || MAX_BURST > 255 || STARVE_LIMIT < 1) begin : g_param_check
    $error("bus_arbiter_6502: MAX_BURST must be 1..255 and STARVE_LIMIT at least 1");
  end

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [7:0]  r_burst_cnt;
  logic [7:0]  w_burst_cnt_next;
  logic [1:0]  r_rd_owner;
  logic [1:0]  w_rd_owner_next;
  logic [7:0]  r_cpu_din;
  logic [7:0]  r_dma_rdata;

  logic        w_cpu_phase;
  logic        w_dma_access;
  logic        w_burst_last;
  logic        w_starved;
  logic        w_grant;
  logic        w_dma_rvalid;

  logic [15:0] w_mem_addr;
  logic [7:0]  w_mem_wdata;
  logic        w_mem_we;
  logic        w_mem_rd;

  assign w_cpu_phase  = (r_state == ST_CPU);
  assign w_dma_access = (r_state == ST_DMA) & io_bus.dma_req;
  assign w_burst_last = (r_burst_cnt == 8'(MAX_BURST - 1));
  assign w_grant      = w_cpu_phase & io_bus.dma_req & io_bus.cpu_rd & (io_bus.cpu_sync | w_starved);

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] r_starve_cnt;

  // Once saturated, any CPU read becomes a legal handoff point.
  assign w_starved = (r_starve_cnt == SW'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (w_grant) begin
      r_starve_cnt <= '0;
    end else if (w_cpu_phase && io_bus.dma_req && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + SW'(1);
    end
  end
`else
  assign w_starved = 1'b0;
`endif

  always_comb begin
    w_state_next     = r_state;
    w_burst_cnt_next = r_burst_cnt;
    case (r_state)
      ST_CPU: begin
        if (w_grant) begin
          w_state_next = ST_HANDOFF;
        end
      end
      ST_HANDOFF: begin
        w_state_next     = ST_DMA;
        w_burst_cnt_next = '0;
      end
      ST_DMA: begin
        if (!io_bus.dma_req) begin
          w_state_next = ST_RETURN;
        end else begin
          w_burst_cnt_next = r_burst_cnt + 8'd1;
          if (w_burst_last) begin
            w_state_next = ST_RETURN;
          end
        end
      end
      ST_RETURN: begin
        w_state_next     = ST_CPU;
        w_burst_cnt_next = '0;
      end
      default: begin
        w_state_next     = ST_CPU;
        w_burst_cnt_next = '0;
      end
    endcase
  end

  // RAM port mux; a CPU write beats a simultaneous CPU read.
  always_comb begin
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_mem_we    = 1'b0;
    w_mem_rd    = 1'b0;
    if (!reset) begin
      if (w_cpu_phase) begin
        w_mem_addr  = io_bus.cpu_addr;
        w_mem_wdata = io_bus.cpu_dout;
        w_mem_we    = io_bus.cpu_we;
        w_mem_rd    = io_bus.cpu_rd & ~io_bus.cpu_we;
      end else if (w_dma_access) begin
        w_mem_addr  = io_bus.dma_addr;
        w_mem_wdata = io_bus.dma_wdata;
        w_mem_we    = io_bus.dma_we;
        w_mem_rd    = ~io_bus.dma_we;
      end
    end
  end

  always_comb begin
    w_rd_owner_next = OWN_NONE;
    if (w_mem_rd) begin
      w_rd_owner_next = w_cpu_phase ? OWN_CPU : OWN_DMA;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_CPU;
      r_burst_cnt <= '0;
      r_rd_owner  <= OWN_NONE;
      r_cpu_din   <= '0;
      r_dma_rdata <= '0;
    end else begin
      r_state     <= w_state_next;
      r_burst_cnt <= w_burst_cnt_next;
      r_rd_owner  <= w_rd_owner_next;
      if (r_rd_owner == OWN_CPU) begin
        r_cpu_din <= io_bus.mem_rdata;
      end
      if (r_rd_owner == OWN_DMA) begin
        r_dma_rdata <= io_bus.mem_rdata;
      end
    end
  end

  // Read data passes straight through in its delivery cycle, then is held.
  assign w_dma_rvalid      = ~reset & (r_rd_owner == OWN_DMA);
  assign io_bus.cpu_rdy    = reset | w_cpu_phase;
  assign io_bus.cpu_din    = (!reset && r_rd_owner == OWN_CPU) ? io_bus.mem_rdata : r_cpu_din;
  assign io_bus.dma_gnt    = ~reset & w_dma_access;
  assign io_bus.dma_rvalid = w_dma_rvalid;
  assign io_bus.dma_rdata  = w_dma_rvalid ? io_bus.mem_rdata : r_dma_rdata;
  assign io_bus.mem_addr   = w_mem_addr;
  assign io_bus.mem_wdata  = w_mem_wdata;
  assign io_bus.mem_we     = w_mem_we;
  assign io_bus.mem_rd     = w_mem_rd;

endmodule

// File: tb/tb_bus_arbiter_6502.sv
// Bench for bus_arbiter_6502: directed scenarios plus random traffic against a cycle-level
// reference model that tracks bus ownership windows and a shadow copy of RAM.
module tb_bus_arbiter_6502;

  localparam int MAX_BURST    = 8;
  localparam int STARVE_LIMIT = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct packed {
    logic        rst;
    logic [15:0] ca;
    logic [7:0]  cd;
    logic        cwe;
    logic        crd;
    logic        csync;
    logic        dreq;
    logic        dwe;
    logic [15:0] da;
    logic [7:0]  dd;
  } stim_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_arbiter_6502_if bus ();

  bus_arbiter_6502 #(
    .MAX_BURST    (MAX_BURST),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  // Synchronous RAM with one cycle read latency.
  logic [7:0] ram [0:65535] = '{default: 8'h00};
  logic [7:0] ram_q = 8'h00;
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd) ram_q <= ram[bus.mem_addr];
  end
  assign bus.mem_rdata = ram_q;

  // Reference model: ownership windows, burst length, starvation wait, shadow RAM.
  logic [7:0] ref_mem [0:65535] = '{default: 8'h00};
  bit         m_lead, m_turn, m_trail;
  int         m_done, m_wait;
  int         pend_own;        // 0 nothing pending, 1 CPU read, 2 DMA read
  logic [7:0] pend_data;
  logic [7:0] e_cpu_din, e_dma_rdata;

  int         n_checks = 0;
  int         n_errors = 0;
  int         gnt_cnt  = 0;
  logic       obs_gnt, obs_rdy, obs_rvalid;
  logic [7:0] obs_cpu_din, obs_dma_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic model_clear();
    m_lead = 0; m_turn = 0; m_trail = 0;
    m_done = 0; m_wait = 0;
    pend_own = 0; pend_data = 8'h00;
    e_cpu_din = 8'h00; e_dma_rdata = 8'h00;
  endtask

  task automatic run_cycle(input stim_t s);
    bit          running;
    bit          starved;
    bit          a_we, a_rd;
    int          a_own;
    logic [15:0] a_addr;
    logic [7:0]  a_data;
    @(negedge clk);
    reset         = s.rst;
    bus.cpu_addr  = s.ca;
    bus.cpu_dout  = s.cd;
    bus.cpu_we    = s.cwe;
    bus.cpu_rd    = s.crd;
    bus.cpu_sync  = s.csync;
    bus.dma_req   = s.dreq;
    bus.dma_we    = s.dwe;
    bus.dma_addr  = s.da;
    bus.dma_wdata = s.dd;
    #1;
    obs_gnt       = bus.dma_gnt;
    obs_rdy       = bus.cpu_rdy;
    obs_rvalid    = bus.dma_rvalid;
    obs_cpu_din   = bus.cpu_din;
    obs_dma_rdata = bus.dma_rdata;
    if (obs_gnt === 1'b1) gnt_cnt++;
    a_we = 0; a_rd = 0; a_own = 0; a_addr = '0; a_data = '0;
    running = !(m_lead || m_turn || m_trail);
    if (s.rst) begin
      chk("rst_cpu_rdy", bus.cpu_rdy, 1);
      chk("rst_dma_gnt", bus.dma_gnt, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_rd", bus.mem_rd, 0);
      chk("rst_dma_rvalid", bus.dma_rvalid, 0);
    end else begin
      if (pend_own == 1) e_cpu_din = pend_data;
      if (pend_own == 2) e_dma_rdata = pend_data;
      if (running) begin
        a_own = 1; a_addr = s.ca; a_data = s.cd;
        a_we = s.cwe;
        a_rd = s.crd && !s.cwe;
      end else if (m_turn && s.dreq) begin
        a_own = 2; a_addr = s.da; a_data = s.dd;
        a_we = s.dwe;
        a_rd = !s.dwe;
      end
      chk("cpu_rdy", bus.cpu_rdy, running);
      chk("dma_gnt", bus.dma_gnt, m_turn && s.dreq);
      chk("mem_we", bus.mem_we, a_we);
      chk("mem_rd", bus.mem_rd, a_rd);
      if (a_we || a_rd) chk("mem_addr", bus.mem_addr, a_addr);
      if (a_we) chk("mem_wdata", bus.mem_wdata, a_data);
      chk("cpu_din", bus.cpu_din, e_cpu_din);
      chk("dma_rvalid", bus.dma_rvalid, pend_own == 2);
      chk("dma_rdata", bus.dma_rdata, e_dma_rdata);
    end
    @(posedge clk);
    if (s.rst) begin
      model_clear();
    end else begin
      if (a_we) ref_mem[a_addr] = a_data;
      if (a_rd) begin
        pend_own  = a_own;
        pend_data = ref_mem[a_addr];
      end else begin
        pend_own = 0;
      end
      if (m_lead) begin
        m_lead = 0; m_turn = 1; m_done = 0;
      end else if (m_turn) begin
        if (!s.dreq) begin
          m_turn = 0; m_trail = 1;
        end else begin
          m_done++;
          if (m_done == MAX_BURST) begin
            m_turn = 0; m_trail = 1;
          end
        end
      end else if (m_trail) begin
        m_trail = 0; m_done = 0;
      end else begin
        starved = GUARD && (m_wait >= STARVE_LIMIT);
        if (s.dreq && s.crd && (s.csync || starved)) begin
          m_lead = 1; m_wait = 0;
        end else if (s.dreq && m_wait < STARVE_LIMIT) begin
          m_wait++;
        end
      end
    end
  endtask

  // Opcode fetch at addr with DMA request asserted.
  function automatic stim_t fetch_with_req(input logic [15:0] addr, input logic dwe,
                                           input logic [15:0] da, input logic [7:0] dd);
    stim_t s;
    s = idle();
    s.crd = 1; s.csync = 1; s.ca = addr;
    s.dreq = 1; s.dwe = dwe; s.da = da; s.dd = dd;
    return s;
  endfunction

  initial begin
    stim_t s;
    bit    dreq_r;
    int    sel;
    model_clear();

    // Reset
    s = idle(); s.rst = 1;
    run_cycle(s); run_cycle(s);
    run_cycle(idle());
    chk("post_reset_rdy", obs_rdy, 1);
    chk("post_reset_gnt", obs_gnt, 0);
    $display("reset: cpu_rdy=%0d dma_gnt=%0d", obs_rdy, obs_gnt);

    // CPU write then read back
    s = idle(); s.cwe = 1; s.ca = 16'h0200; s.cd = 8'h01;
    run_cycle(s);
    s = idle(); s.crd = 1; s.ca = 16'h0200;
    run_cycle(s);
    run_cycle(idle());
    chk("cpu_readback", obs_cpu_din, 8'h01);
    $display("cpu path: read 0x0200 -> 0x%02h", obs_cpu_din);

    // DMA write burst of three, then the CPU reads one back
    gnt_cnt = 0;
    run_cycle(fetch_with_req(16'h0005, 1'b1, 16'h0300, 8'hA0));
    run_cycle(fetch_with_req(16'h0006, 1'b1, 16'h0300, 8'hA0));
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.dreq = 1; s.dwe = 1;
      s.da = 16'h0300 + 16'(i); s.dd = 8'hA0 + 8'(i);
      run_cycle(s);
    end
    for (int i = 0; i < 3; i++) run_cycle(idle());
    chk("burst_grants", gnt_cnt, 3);
    s = idle(); s.crd = 1; s.ca = 16'h0301;
    run_cycle(s);
    run_cycle(idle());
    chk("dma_write_readback", obs_cpu_din, 8'hA1);
    $display("dma burst: grants=%0d readback 0x0301 -> 0x%02h", gnt_cnt, obs_cpu_din);

    // Burst limit with the request held high; no re-grant without a new sync
    gnt_cnt = 0;
    run_cycle(fetch_with_req(16'h0010, 1'b0, 16'h0300, 8'h00));
    for (int i = 0; i < 13; i++) begin
      s = idle(); s.crd = 1; s.ca = 16'h0011; s.dreq = 1;
      s.da = 16'h0300 + 16'(i); s.dwe = 0;
      run_cycle(s);
    end
    chk("limit_grants", gnt_cnt, MAX_BURST);
    chk("limit_cpu_back", obs_rdy, 1);
    run_cycle(fetch_with_req(16'h0012, 1'b0, 16'h0300, 8'h00));
    s = idle(); s.crd = 1; s.ca = 16'h0013;
    for (int i = 0; i < 4; i++) run_cycle(s);
    $display("burst limit: grants=%0d", gnt_cnt);

    // DMA read of 0x0200 holding 0x05
    s = idle(); s.cwe = 1; s.ca = 16'h0200; s.cd = 8'h05;
    run_cycle(s);
    run_cycle(fetch_with_req(16'h0020, 1'b0, 16'h0200, 8'h00));
    run_cycle(fetch_with_req(16'h0021, 1'b0, 16'h0200, 8'h00));
    s = idle(); s.dreq = 1; s.da = 16'h0200;
    run_cycle(s);
    run_cycle(idle());
    chk("dma_read_valid", obs_rvalid, 1);
    chk("dma_read_data", obs_dma_rdata, 8'h05);
    run_cycle(idle());
    run_cycle(idle());
    $display("dma read: 0x0200 -> 0x%02h", obs_dma_rdata);

    // Reset in the middle of a burst, right after a DMA read
    run_cycle(fetch_with_req(16'h0030, 1'b1, 16'h0210, 8'h5A));
    run_cycle(fetch_with_req(16'h0031, 1'b1, 16'h0210, 8'h5A));
    s = idle(); s.dreq = 1; s.dwe = 1; s.da = 16'h0210; s.dd = 8'h5A;
    run_cycle(s);
    s.dwe = 0;
    run_cycle(s);
    s.rst = 1;
    run_cycle(s);
    s = idle(); s.dreq = 1;
    run_cycle(s);
    chk("midrst_rdy", obs_rdy, 1);
    chk("midrst_gnt", obs_gnt, 0);
    chk("midrst_rvalid", obs_rvalid, 0);
    $display("mid-burst reset: cpu_rdy=%0d dma_gnt=%0d dma_rvalid=%0d", obs_rdy, obs_gnt, obs_rvalid);

`ifdef ARB_STARVE_GUARD_EN
    // Starvation guard: no sync, grant on the first read after the limit
    s = idle(); s.rst = 1;
    run_cycle(s);
    s = idle(); s.dreq = 1;
    for (int i = 0; i < STARVE_LIMIT; i++) run_cycle(s);
    s.crd = 1; s.ca = 16'h0040;
    run_cycle(s);
    run_cycle(s);
    chk("starve_handoff_rdy", obs_rdy, 0);
    s = idle();
    for (int i = 0; i < 3; i++) run_cycle(s);
    $display("starvation guard: handoff taken without sync");
`endif

    // Random traffic
    dreq_r = 0;
    for (int i = 0; i < 3000; i++) begin
      s = idle();
      if ($urandom_range(0, 7) == 0) dreq_r = ~dreq_r;
      s.rst  = ($urandom_range(0, 299) == 0);
      sel    = int'($urandom_range(0, 3));
      s.ca   = 16'h0200 + 16'($urandom_range(0, 15));
      s.cd   = 8'($urandom);
      s.cwe  = (sel == 1);
      s.crd  = (sel >= 2);
      s.csync = (sel == 3) && ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 15) == 0) begin
        s.cwe = 1; s.crd = 1;
      end
      s.dreq = dreq_r;
      s.dwe  = $urandom_range(0, 1) == 1;
      s.da   = 16'h0200 + 16'($urandom_range(0, 15));
      s.dd   = 8'($urandom);
      run_cycle(s);
    end
    $display("random traffic: 3000 cycles");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
